rca_word_sequencer: RTL and testbench

- Multi-cycle sequencer that drives the team's combinational 8-bit ripple-carry adder over consecutive byte slices. It performs WORDS*8-bit additions one slice per cycle and chains the carry between slices in a register.
- Sits directly upstream of the 8-bit adder, feeding it operand slices and carry-in, and directly downstream of it, capturing Sum and Cout.
- Exposes a valid/ready request and response interface to the datapath.

---
 rtl/rca_word_sequencer.sv | 123 ++++++++++++
 tb/tb_rca_word_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rca_word_sequencer.sv
// Multi-cycle WORDS*8-bit adder: drives an external 8-bit ripple-carry adder one byte slice per cycle.
// Optional signed-overflow output Ovf is enabled by defining RCA_SEQ_OVF_EN.
`timescale 1ns/1ps
module rca_word_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [8*WORDS-1:0]   A,
    input  logic [8*WORDS-1:0]   B,
    input  logic                 Cin,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [8*WORDS-1:0]   Sum,
    output logic                 Cout,
    output logic [7:0]           AddA,
    output logic [7:0]           AddB,
    output logic                 AddCin,
    input  logic [7:0]           AddSum,
    input  logic                 AddCout
`ifdef RCA_SEQ_OVF_EN
    ,
    output logic                 Ovf
`endif
);

    localparam int W    = 8 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic [IDXW-1:0] r_idx;
    logic            w_last;
`ifdef RCA_SEQ_OVF_EN
    logic            r_ovf;
    assign Ovf = r_ovf;
`endif

    assign w_last   = (r_idx == IDXW'(WORDS - 1));
    assign InReady  = (r_state == S_IDLE);
    assign OutValid = (r_state == S_DONE);
    assign Sum      = r_sum;
    assign Cout     = r_carry;

    // Slice mux toward the external adder; quiet (all zero) outside RUN.
    always_comb begin
        AddA   = '0;
        AddB   = '0;
        AddCin = 1'b0;
        if (r_state == S_RUN) begin
            AddCin = r_carry;
            for (int unsigned k = 0; k < WORDS; k++) begin
                if (r_idx == IDXW'(k)) begin
                    AddA = r_a[8*k +: 8];
                    AddB = r_b[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
`ifdef RCA_SEQ_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (InValid) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_carry <= Cin;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int unsigned k = 0; k < WORDS; k++) begin
                        if (r_idx == IDXW'(k)) begin
                            r_sum[8*k +: 8] <= AddSum;
                        end
                    end
                    r_carry <= AddCout;
                    if (w_last) begin
                        r_idx   <= '0;
                        r_state <= S_DONE;
`ifdef RCA_SEQ_OVF_EN
                        // Top slice's sum MSB is the full-width sign bit.
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) && (AddSum[7] != r_a[W-1]);
`endif
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (OutReady) begin
                        r_state <= S_IDLE;
`ifdef RCA_SEQ_OVF_EN
                        r_ovf   <= 1'b0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Scoreboard bench for rca_word_sequencer (WORDS=4) with an exact 8-bit adder model attached.
`timescale 1ns/1ps
module tb_rca_word_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         InValid = 1'b0;
    logic         InReady;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         OutValid;
    logic         OutReady = 1'b1;
    logic [W-1:0] Sum;
    logic         Cout;
    logic [7:0]   AddA, AddB, AddSum;
    logic         AddCin, AddCout;
`ifdef RCA_SEQ_OVF_EN
    logic         Ovf;
`endif

    rca_word_sequencer #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady),
        .A(A), .B(B), .Cin(Cin), .OutValid(OutValid), .OutReady(OutReady),
        .Sum(Sum), .Cout(Cout), .AddA(AddA), .AddB(AddB), .AddCin(AddCin),
        .AddSum(AddSum), .AddCout(AddCout)
`ifdef RCA_SEQ_OVF_EN
        , .Ovf(Ovf)
`endif
    );

    always #5 clk = ~clk;

    // External 8-bit ripple-carry adder, modelled as plain arithmetic.
    assign {AddCout, AddSum} = {1'b0, AddA} + {1'b0, AddB} + {8'd0, AddCin};

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   last_out_hs = -1;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] t;
        exp_t e;
        t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return e;
    endfunction

    // Monitor: every result handshake is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && OutValid && OutReady) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                m_e = q.pop_front();
                chk("sum", Sum, m_e.sum);
                chk("cout", Cout, m_e.cout);
`ifdef RCA_SEQ_OVF_EN
                chk("ovf", Ovf, m_e.ovf);
`endif
            end
            last_out_hs = cyc + 1;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 OutReady = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit push);
        int n;
        InValid = 1'b1;
        A = a;
        B = b;
        Cin = c;
        n = 0;
        @(negedge clk);
        while (!InReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!InReady) begin
            chk("accept_timeout", 64'd0, 64'd1);
            InValid = 1'b0;
            return;
        end
        if (push) q.push_back(model(a, b, c));
        acc_cyc = cyc + 1;
        @(posedge clk);
        #1 InValid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        while (!OutValid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(cyc - acc_cyc), 64'(WORDS));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_inready", InReady, 1);
        chk("rst_outvalid", OutValid, 0);
        chk("rst_sum", Sum, 0);
        chk("rst_cout", Cout, 0);
        chk("rst_adda", AddA, 0);
        chk("rst_addb", AddB, 0);
        chk("rst_addcin", AddCin, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Slice carry into the second byte
        OutReady = 1'b1;
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1);
        @(negedge clk);
        chk("run1_adda", AddA, 8'hFF);
        chk("run1_addb", AddB, 8'h01);
        chk("run1_addcin", AddCin, 0);
        wait_out("lat_t1");
        @(posedge clk); #1;

        // Full ripple
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1);
        wait_out("lat_t2");
        @(posedge clk); #1;

        // Backpressure hold with ignored request
        OutReady = 1'b0;
        issue(32'h1234_5678, 32'h8765_4321, 1'b0, 1);
        wait_out("lat_t3");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            InValid = (i >= 3 && i <= 5);
            A = 32'hDEAD_BEEF;
            B = 32'h0BAD_F00D;
            @(negedge clk);
            chk("stall_outvalid", OutValid, 1);
            chk("stall_inready", InReady, 0);
            chk("stall_sum", Sum, 32'h9999_9999);
            chk("stall_cout", Cout, 0);
        end
        @(posedge clk); #1;
        InValid = 1'b0;
        OutReady = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_hs_inready", InReady, 1);
        chk("post_hs_outvalid", OutValid, 0);
`ifdef RCA_SEQ_OVF_EN
        chk("post_hs_ovf", Ovf, 0);
`endif

        // Reset during the second RUN cycle aborts the operation
        @(posedge clk); #1;
        issue(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("run2_adda", AddA, 8'hA5);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_inready", InReady, 1);
        chk("abort_outvalid", OutValid, 0);
        chk("abort_sum", Sum, 0);
        chk("abort_cout", Cout, 0);
        chk("abort_adda", AddA, 0);
        @(posedge clk); #1;
        issue(32'h0000_0001, 32'h0000_0001, 1'b0, 1);
        wait_out("lat_after_abort");
        @(posedge clk); #1;

        // Back-to-back requests
        issue(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1);
        issue(32'h0102_0304, 32'h1020_3040, 1'b1, 1);
        chk("b2b_accept", 64'(acc_cyc), 64'(last_out_hs + 1));
        wait_out("lat_b2b");
        @(posedge clk); #1;

        // Signed overflow boundaries
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1);
        wait_out("lat_ovf1");
        @(posedge clk); #1;
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1);
        wait_out("lat_ovf2");
        @(posedge clk); #1;

        // Randomized operands with random result backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1);
        end
        rand_ready = 1'b0;
        @(posedge clk); #1;
        OutReady = 1'b1;
        for (int n = 0; n < 200 && q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        chk("drain", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
